dot_result_collector: RTL and testbench

Downstream consumer of the 256-input floating-point adder tree. Captures each 32-bit row sum on the tree's finish pulse, tags it with its row index, and buffers it in a small FIFO. Results drain to the next stage (vector update / memory writer) over a valid/ready stream. Signals frame completion once all rows of a matrix-vector pass have been delivered.

---
 rtl/dot_result_collector.sv | 143 ++++++++++++++
 tb/tb_dot_result_collector.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_result_collector.sv
// rtl/dot_result_collector.sv - tags adder-tree row sums with their index and buffers them for a valid/ready stream
// Optional feature macro: COLLECTOR_MAXABS_EN (adds max_abs running magnitude output)
module dot_result_collector #(
    parameter int DEPTH = 16,
    parameter int NROWS = 256,
    parameter int IW    = (NROWS > 1) ? $clog2(NROWS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          sum_valid,
    input  logic [31:0]   sum_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [IW-1:0] out_index,
    output logic          out_last,
    output logic          frame_done,
    output logic          busy,
    output logic          overflow,
    output logic          err_unexpected
`ifdef COLLECTOR_MAXABS_EN
    ,
    output logic [31:0]   max_abs
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = IW + 33;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] row_cnt;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   rd_next;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic          last_dropped;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          drop;
    logic          is_last_row;
    logic          drain_done;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_next = rd_ptr + 1'b1;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Head fields are forced to zero while empty so reset clears them without resetting the array
    assign out_valid = !empty;
    assign out_data  = empty ? 32'd0 : head[31:0];
    assign out_last  = empty ? 1'b0 : head[32];
    assign out_index = empty ? '0 : head[EW-1:33];
    assign busy      = (state != S_IDLE);

    assign pop         = out_valid && out_ready;
    assign is_last_row = (row_cnt == IW'(NROWS - 1));
    assign push_req    = (state == S_COLLECT) && sum_valid && !frame_start;
    assign push_ok     = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;

    // A dropped last row leaves no out_last entry, so the frame ends when the FIFO runs dry
    assign drain_done = (state == S_DRAIN) && !frame_start &&
                        ((pop && out_last) ||
                         (last_dropped && (empty || (pop && rd_next == wr_ptr))));

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {row_cnt, is_last_row, sum_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            row_cnt        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            last_dropped   <= 1'b0;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            frame_done <= drain_done;
            if (frame_start) begin
                state          <= S_COLLECT;
                row_cnt        <= '0;
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                last_dropped   <= 1'b0;
                overflow       <= 1'b0;
                err_unexpected <= 1'b0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_next;
                end
                if (sum_valid && state != S_COLLECT) begin
                    err_unexpected <= 1'b1;
                end
                if (push_req) begin
                    row_cnt <= row_cnt + 1'b1;
                    if (drop) begin
                        overflow <= 1'b1;
                    end
                    if (is_last_row) begin
                        last_dropped <= drop;
                        state        <= S_DRAIN;
                    end
                end
                if (drain_done) begin
                    state <= S_IDLE;
                end
            end
        end
    end

`ifdef COLLECTOR_MAXABS_EN
    logic [31:0] mag;
    assign mag = {1'b0, sum_in[30:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_abs <= 32'd0;
        end else if (frame_start) begin
            max_abs <= 32'd0;
        end else if (push_ok && mag > max_abs) begin
            max_abs <= mag;
        end
    end
`endif

endmodule

// File: tb/tb_dot_result_collector.sv
// tb/tb_dot_result_collector.sv - self-checking bench for dot_result_collector (NROWS=8, DEPTH=4)
module tb_dot_result_collector;

    localparam int NR = 8;
    localparam int DP = 4;

    typedef struct packed {
        logic [2:0]  idx;
        logic        last;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        sum_valid;
    logic [31:0] sum_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_index;
    logic        out_last;
    logic        frame_done;
    logic        busy;
    logic        overflow;
    logic        err_unexpected;
`ifdef COLLECTOR_MAXABS_EN
    logic [31:0] max_abs;
`endif

    int errors = 0;
    int checks = 0;

    ent_t        mq[$];
    int          m_state;
    int          m_row;
    bit          m_ovf;
    bit          m_err;
    bit          m_done;
    bit          m_ldrop;
    logic [31:0] m_max;

    dot_result_collector #(.DEPTH(DP), .NROWS(NR)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .sum_valid(sum_valid),
        .sum_in(sum_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_index(out_index),
        .out_last(out_last),
        .frame_done(frame_done),
        .busy(busy),
        .overflow(overflow),
        .err_unexpected(err_unexpected)
`ifdef COLLECTOR_MAXABS_EN
        ,
        .max_abs(max_abs)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_row   = 0;
        m_ovf   = 0;
        m_err   = 0;
        m_done  = 0;
        m_ldrop = 0;
        m_max   = 0;
    endtask

    // Queue-level reference: 0=IDLE, 1=COLLECT, 2=DRAIN
    task automatic model_step(input bit fs, input bit sv, input logic [31:0] d, input bit rdy);
        int   pre;
        bit   pop;
        bit   done;
        bit   lastrow;
        ent_t h;
        pre    = m_state;
        pop    = (mq.size() > 0) && rdy;
        done   = 0;
        m_done = 0;
        if (fs) begin
            mq.delete();
            m_row   = 0;
            m_ovf   = 0;
            m_err   = 0;
            m_ldrop = 0;
            m_max   = 0;
            m_state = 1;
        end else begin
            if (pre == 2 && m_ldrop && mq.size() == 0) done = 1;
            if (pop) begin
                h = mq.pop_front();
                if (pre == 2 && (h.last || (m_ldrop && mq.size() == 0))) done = 1;
            end
            if (sv) begin
                if (pre != 1) begin
                    m_err = 1;
                end else begin
                    lastrow = (m_row == NR - 1);
                    if (mq.size() < DP) begin
                        mq.push_back(ent_t'({3'(m_row), lastrow, d}));
                        if ({1'b0, d[30:0]} > m_max) m_max = {1'b0, d[30:0]};
                    end else begin
                        m_ovf = 1;
                        if (lastrow) m_ldrop = 1;
                    end
                    m_row++;
                    if (lastrow) m_state = 2;
                end
            end
            if (done) begin
                m_state = 0;
                m_done  = 1;
            end
        end
    endtask

    task automatic cycle(input bit fs, input bit sv, input logic [31:0] d, input bit rdy);
        frame_start = fs;
        sum_valid   = sv;
        sum_in      = d;
        out_ready   = rdy;
        @(posedge clk);
        model_step(fs, sv, d, rdy);
        @(negedge clk);
        frame_start = 1'b0;
        sum_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        frame_start = 0; sum_valid = 0; sum_in = 0; out_ready = 0;
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({out_valid, out_data, out_index, out_last, frame_done, busy, overflow, err_unexpected} !== 40'd0)
            begin errors++; $display("FAIL reset_outputs: got %h expected 0", {out_valid, out_data, out_index, out_last, frame_done, busy, overflow, err_unexpected}); end
`ifdef COLLECTOR_MAXABS_EN
        checks++;
        if (max_abs !== 32'd0) begin errors++; $display("FAIL reset_max_abs: got %h expected 0", max_abs); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, frame_done} !== 3'b000) begin errors++; $display("FAIL post_reset_idle: got %b expected 000", {out_valid, busy, frame_done}); end
    endtask

    task automatic test_in_order();
        logic [31:0] v[8] = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h3F000000,
                              32'h3E800000, 32'hBF000000, 32'h3F400000, 32'h00000001};
        cycle(1, 0, 0, 1);
        checks++;
        if ({busy, out_valid} !== 2'b10) begin errors++; $display("FAIL inorder_start: got %b expected 10", {busy, out_valid}); end
        for (int i = 0; i < NR; i++) begin
            cycle(0, 1, v[i], 1);
            checks++;
            if ({out_valid, out_index, out_last, out_data} !== {1'b1, 3'(i), (i == NR - 1), v[i]})
                begin errors++; $display("FAIL inorder_head%0d: got %h expected %h", i, {out_valid, out_index, out_last, out_data}, {1'b1, 3'(i), (i == NR - 1), v[i]}); end
        end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL inorder_early_done: got %b expected 0", frame_done); end
        cycle(0, 0, 0, 1);
        checks++;
        if ({frame_done, busy, out_valid} !== 3'b100) begin errors++; $display("FAIL inorder_done: got %b expected 100", {frame_done, busy, out_valid}); end
`ifdef COLLECTOR_MAXABS_EN
        checks++;
        if (max_abs !== 32'h40400000) begin errors++; $display("FAIL inorder_max_abs: got %h expected 40400000", max_abs); end
`endif
        cycle(0, 0, 0, 1);
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL inorder_done_pulse: got %b expected 0", frame_done); end
    endtask

    task automatic test_overflow();
        logic [31:0] d[8];
        logic [31:0] mx;
        mx = 0;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < NR; i++) begin
            d[i] = $urandom;
            if (i < DP && {1'b0, d[i][30:0]} > mx) mx = {1'b0, d[i][30:0]};
            cycle(0, 1, d[i], 0);
        end
        checks++;
        if ({overflow, busy, out_index, out_data} !== {1'b1, 1'b1, 3'd0, d[0]})
            begin errors++; $display("FAIL ovf_state: got %h expected %h", {overflow, busy, out_index, out_data}, {1'b1, 1'b1, 3'd0, d[0]}); end
        for (int i = 0; i < DP; i++) begin
            checks++;
            if ({out_valid, out_index, out_last, out_data, frame_done} !== {1'b1, 3'(i), 1'b0, d[i], 1'b0})
                begin errors++; $display("FAIL ovf_pop%0d: got %h expected %h", i, {out_valid, out_index, out_last, out_data, frame_done}, {1'b1, 3'(i), 1'b0, d[i], 1'b0}); end
            cycle(0, 0, 0, 1);
        end
        checks++;
        if ({frame_done, busy, out_valid, overflow} !== 4'b1001) begin errors++; $display("FAIL ovf_done: got %b expected 1001", {frame_done, busy, out_valid, overflow}); end
`ifdef COLLECTOR_MAXABS_EN
        checks++;
        if (max_abs !== mx) begin errors++; $display("FAIL ovf_max_abs: got %h expected %h", max_abs, mx); end
`endif
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d[8];
        bit seen;
        for (int i = 0; i < NR; i++) d[i] = $urandom;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < DP; i++) cycle(0, 1, d[i], 0);
        cycle(0, 1, d[DP], 1);
        checks++;
        if ({overflow, out_index} !== {1'b0, 3'd1}) begin errors++; $display("FAIL full_pushpop: got %h expected %h", {overflow, out_index}, {1'b0, 3'd1}); end
        for (int k = 1; k <= DP; k++) begin
            checks++;
            if ({out_valid, out_index, out_data} !== {1'b1, 3'(k), d[k]})
                begin errors++; $display("FAIL full_order%0d: got %h expected %h", k, {out_valid, out_index, out_data}, {1'b1, 3'(k), d[k]}); end
            cycle(0, 0, 0, 1);
        end
        for (int i = DP + 1; i < NR; i++) begin
            cycle(0, 1, d[i], 1);
            checks++;
            if ({out_index, out_data} !== {3'(i), d[i]}) begin errors++; $display("FAIL full_tail%0d: got %h expected %h", i, {out_index, out_data}, {3'(i), d[i]}); end
        end
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            cycle(0, 0, 0, 1);
            seen = frame_done;
        end
        checks++;
        if (!seen || overflow !== 1'b0) begin errors++; $display("FAIL full_frame_done: got done=%0d ovf=%b expected done=1 ovf=0", seen, overflow); end
    endtask

    task automatic test_unexpected();
        cycle(0, 1, 32'h00001234, 0);
        checks++;
        if ({err_unexpected, out_valid, busy} !== 3'b100) begin errors++; $display("FAIL unexp_idle: got %b expected 100", {err_unexpected, out_valid, busy}); end
        cycle(1, 1, 32'h00005678, 0);
        checks++;
        if ({err_unexpected, out_valid, busy} !== 3'b001) begin errors++; $display("FAIL unexp_fs_wins: got %b expected 001", {err_unexpected, out_valid, busy}); end
        cycle(0, 1, 32'h0000AAAA, 0);
        checks++;
        if ({out_index, out_data, err_unexpected} !== {3'd0, 32'h0000AAAA, 1'b0})
            begin errors++; $display("FAIL unexp_first_row: got %h expected %h", {out_index, out_data, err_unexpected}, {3'd0, 32'h0000AAAA, 1'b0}); end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        cycle(0, 1, 32'h0000BBBB, 0);
        cycle(1, 0, 0, 0);
        checks++;
        if ({out_valid, busy, overflow} !== 3'b010) begin errors++; $display("FAIL abort_flush: got %b expected 010", {out_valid, busy, overflow}); end
        for (int i = 0; i < NR; i++) begin
            cycle(0, 1, 32'hC0DE0000 + i, 1);
            dones += int'(frame_done);
            if (i == 0) begin
                checks++;
                if ({out_index, out_data} !== {3'd0, 32'hC0DE0000})
                    begin errors++; $display("FAIL abort_restart: got %h expected %h", {out_index, out_data}, {3'd0, 32'hC0DE0000}); end
            end
        end
        for (int t = 0; t < 10; t++) begin
            cycle(0, 0, 0, 1);
            dones += int'(frame_done);
        end
        checks++;
        if (dones !== 1 || busy !== 1'b0) begin errors++; $display("FAIL abort_done_count: got %0d busy=%b expected 1 busy=0", dones, busy); end
    endtask

    task automatic test_reset_drain();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < NR; i++) cycle(0, 1, $urandom, 0);
        cycle(0, 0, 0, 1);
        checks++;
        if ({busy, out_valid, out_index} !== {1'b1, 1'b1, 3'd1}) begin errors++; $display("FAIL rstdrain_pre: got %h expected %h", {busy, out_valid, out_index}, {1'b1, 1'b1, 3'd1}); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({out_valid, out_data, out_index, out_last, frame_done, busy, overflow, err_unexpected} !== 40'd0)
            begin errors++; $display("FAIL rstdrain_async: got %h expected 0", {out_valid, out_data, out_index, out_last, frame_done, busy, overflow, err_unexpected}); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 1);
        cycle(0, 1, 32'h12345678, 1);
        checks++;
        if ({out_index, out_data, overflow, busy} !== {3'd0, 32'h12345678, 1'b0, 1'b1})
            begin errors++; $display("FAIL rstdrain_restart: got %h expected %h", {out_index, out_data, overflow, busy}, {3'd0, 32'h12345678, 1'b0, 1'b1}); end
    endtask

    task automatic test_random();
        bit fs;
        bit sv;
        bit rdy;
        cycle(1, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            fs  = ($urandom_range(0, 149) == 0);
            sv  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 7);
            cycle(fs, sv, $urandom, rdy);
            checks++;
            if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", n, out_valid, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++;
                if ({out_index, out_last, out_data} !== mq[0]) begin errors++; $display("FAIL rand_head@%0d: got %h expected %h", n, {out_index, out_last, out_data}, mq[0]); end
            end
            checks++;
            if ({frame_done, busy} !== {m_done, m_state != 0}) begin errors++; $display("FAIL rand_done_busy@%0d: got %b expected %b", n, {frame_done, busy}, {m_done, m_state != 0}); end
            checks++;
            if ({overflow, err_unexpected} !== {m_ovf, m_err}) begin errors++; $display("FAIL rand_flags@%0d: got %b expected %b", n, {overflow, err_unexpected}, {m_ovf, m_err}); end
`ifdef COLLECTOR_MAXABS_EN
            checks++;
            if (max_abs !== m_max) begin errors++; $display("FAIL rand_max_abs@%0d: got %h expected %h", n, max_abs, m_max); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_overflow();
        test_full_push_pop();
        test_unexpected();
        test_abort();
        test_reset_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
